wash_phase_timer: RTL and testbench
===================================

// Module: wash_phase_timer
// PURPOSE
//  Parametrised phase timer for the washing-machine controller. Counts a per-step
//  duration in ticks at a normal or accelerated rate. All logic runs on clk; ticks
//  are single-cycle enables, with no derived clocks. Supports pause/resume and abort.
//  Sets a sticky per-step completion flag and a one-cycle done pulse for the sequencer.
// PARAMETERS
//  CLK_HZ   24_000_000  input clock frequency
//  TICK_HZ  10          normal tick rate; DIV_N = CLK_HZ/TICK_HZ
//  ACC_HZ   100         accelerated tick rate; DIV_A = CLK_HZ/ACC_HZ
//  TIME_W   16          width of durations and elapsed time
//  N_STEPS  4           number of steps; localparam STEP_W = max(1,$clog2(N_STEPS))
// PORTS
//  clk         in   1        system clock
//  rst_n       in   1        asynchronous active-low reset
//  i_start     in   1        level; high = run current step, low = abort/idle
//  i_pause     in   1        level; high freezes tick count and prescaler
//  i_acc       in   1        1 = accelerated tick rate
//  i_step      in   STEP_W   step index, sampled on IDLE->RUN
//  i_duration  in   TIME_W   step length in ticks, sampled on IDLE->RUN
//  i_clear     in   1        clears all o_response bits
//  o_response  out  N_STEPS  sticky completion flags, one per step
//  o_done      out  1        one-cycle pulse on step completion
//  o_time      out  TIME_W   elapsed ticks in current step
//  o_remain    out  TIME_W   dur_q - o_time
//  o_busy      out  1        high in RUN or PAUSE
// BEHAVIOUR
//  Reset (async): state=IDLE, prescaler=0, o_time=0, o_response=0, o_done=0, o_busy=0,
//    step_q=0, dur_q=0. o_remain therefore reads 0.
//  Prescaler: counts clk while enabled. Emits tick when cnt >= DIV-1, then cnt<=0.
//    DIV follows i_acc each cycle. A switch to the faster rate with cnt past the
//    new DIV-1 ticks on the next cycle. No tick is lost or doubled on a switch.
//  FSM states: IDLE, RUN, PAUSE, DONE.
//   IDLE : o_time=0, prescaler cleared.
//          If i_start=1, latch step_q/dur_q; next state RUN (1-cycle latency).
//          dur_q=0 is allowed; see RUN.
//   RUN  : prescaler enabled. On tick, o_time<=o_time+1.
//          Completion occurs when dur_q==0, or on a tick with o_time+1==dur_q.
//          On completion: o_done=1 for 1 cycle, o_response[step_q]<=1, state DONE.
//          i_pause=1 -> PAUSE (no tick counted that cycle).
//   PAUSE: prescaler and o_time frozen. i_pause=0 -> RUN, resuming the partial tick.
//   DONE : o_time holds dur_q, o_busy=0. Waits for i_start=0 -> IDLE.
//          This prevents re-triggering the same step.
//  Abort: i_start=0 in RUN or PAUSE -> IDLE next cycle. o_time<=0.
//    No o_done pulse; o_response is unchanged.
//  Priority in RUN: abort > completion > pause.
//  i_step and i_duration changes during RUN, PAUSE or DONE are ignored.
//  i_step >= N_STEPS: o_done still pulses; no o_response bit is set.
//  i_clear applies in any state. If it coincides with completion, the bit being
//    set wins; all other bits clear.
//  o_time never wraps: it saturates at dur_q <= 2^TIME_W-1.
//  Prescaler is 32-bit; DIV values are computed at elaboration and must be >= 1.
// STRUCTURE
//  wm_pkg: state enum (IDLE/RUN/PAUSE/DONE) and a shared function for divider
//    width, div_bits(CLK_HZ,HZ).
//  Sub-module wm_tick_gen: prescaler with inputs en, clr, acc and output tick.
//    Parameters: DIV_N and DIV_A.
//  Top level: FSM, latches, counter and response register.
// TESTING (CLK_HZ=1000, TICK_HZ=10 -> DIV 100, ACC_HZ=100 -> DIV 10)
//  1. step=2, dur=3, acc=0, start held: o_done pulses 300 clk after RUN entry.
//     o_response=4'b0100, o_time=3, state DONE.
//  2. step=1, dur=5, acc=1: done after 50 clk. Then drop start: IDLE, o_time=0.
//     Raise start again: new run completes.
//  3. dur=4, acc=0: pause 250 clk after 150 clk of RUN (o_time=1). Resume.
//     Done at 400 clk of RUN time; o_time never moves during pause.
//  4. Abort: dur=10, drop start at o_time=6: IDLE next cycle, o_time=0.
//     o_done stays 0; o_response unchanged.
//  5. dur=0, step=3: done 1 cycle after RUN, o_response[3]=1.
//     i_clear in the same cycle as the step-0 done: only bit0 set afterwards.
//  6. Async rst_n low mid-RUN (o_time=2): all outputs 0 immediately.
//     Rate switch 0->1 with cnt=50 gives a tick on the next cycle.

Source files
------------

// File: rtl/wm_pkg.sv
// Shared types and helpers for the washing-machine phase timer.
package wm_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StDone
    } state_e;

    // Bits needed to hold a prescaler count for clk_hz/hz, never less than 1.
    function automatic int unsigned div_bits(input int unsigned clk_hz, input int unsigned hz);
        int unsigned div;
        div = clk_hz / hz;
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/wm_tick_gen.sv
// Prescaler producing single-cycle tick enables at a normal or accelerated rate.
module wm_tick_gen #(
    parameter int unsigned DIV_N = 100,
    parameter int unsigned DIV_A = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  logic acc,
    output logic tick
);

    if (DIV_N < 1 || DIV_A < 1) begin : g_div_check
        $error("wm_tick_gen: divider values must be >= 1");
    end

    logic [31:0] cnt_q, cnt_d, lim;

    // Limit follows acc every cycle; >= catches a count already past the faster limit.
    always_comb begin
        lim  = acc ? 32'(DIV_A - 1) : 32'(DIV_N - 1);
        tick = en && (cnt_q >= lim);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 32'd1;
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wash_phase_timer.sv
// Per-step phase timer: FSM, step/duration latches, elapsed counter, sticky flags.
module wash_phase_timer
    import wm_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 24_000_000,
    parameter int unsigned TICK_HZ = 10,
    parameter int unsigned ACC_HZ  = 100,
    parameter int unsigned TIME_W  = 16,
    parameter int unsigned N_STEPS = 4,
    localparam int unsigned STEP_W = (N_STEPS > 1) ? $clog2(N_STEPS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_pause,
    input  logic               i_acc,
    input  logic [STEP_W-1:0]  i_step,
    input  logic [TIME_W-1:0]  i_duration,
    input  logic               i_clear,
    output logic [N_STEPS-1:0] o_response,
    output logic               o_done,
    output logic [TIME_W-1:0]  o_time,
    output logic [TIME_W-1:0]  o_remain,
    output logic               o_busy
);

    localparam int unsigned DIV_N = CLK_HZ / TICK_HZ;
    localparam int unsigned DIV_A = CLK_HZ / ACC_HZ;

    if (div_bits(CLK_HZ, TICK_HZ) > 32 || div_bits(CLK_HZ, ACC_HZ) > 32) begin : g_w_check
        $error("wash_phase_timer: divider does not fit the 32-bit prescaler");
    end

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [TIME_W-1:0]   dur_q, dur_d;
    logic [TIME_W-1:0]   time_q, time_d;
    logic [TIME_W:0]     time_inc;
    logic [N_STEPS-1:0]  resp_q, resp_d;
    logic                done_q, done_d;
    logic                tick, pre_en, pre_clr, complete;

    wm_tick_gen #(
        .DIV_N (DIV_N),
        .DIV_A (DIV_A)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pre_en),
        .clr   (pre_clr),
        .acc   (i_acc),
        .tick  (tick)
    );

    // Extra bit keeps the completion compare free of wrap-around.
    assign time_inc = {1'b0, time_q} + (TIME_W + 1)'(1);

    // FSM next state, counter and prescaler control; RUN priority abort > completion > pause.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        dur_d    = dur_q;
        time_d   = time_q;
        done_d   = 1'b0;
        pre_en   = 1'b0;
        pre_clr  = 1'b0;
        complete = 1'b0;
        unique case (state_q)
            StIdle: begin
                pre_clr = 1'b1;
                time_d  = '0;
                if (i_start) begin
                    step_d  = i_step;
                    dur_d   = i_duration;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!i_start) begin
                    state_d = StIdle;
                    time_d  = '0;
                    pre_clr = 1'b1;
                end else if (dur_q == '0) begin
                    complete = 1'b1;
                end else if (i_pause) begin
                    state_d = StPause;
                end else begin
                    pre_en = 1'b1;
                    if (tick) begin
                        if (time_inc == {1'b0, dur_q}) begin
                            complete = 1'b1;
                        end else begin
                            time_d = time_inc[TIME_W-1:0];
                        end
                    end
                end
                if (complete) begin
                    done_d  = 1'b1;
                    time_d  = dur_q;
                    state_d = StDone;
                end
            end
            StPause: begin
                if (!i_start) begin
                    state_d = StIdle;
                    time_d  = '0;
                    pre_clr = 1'b1;
                end else if (!i_pause) begin
                    state_d = StRun;
                end
            end
            StDone: begin
                pre_clr = 1'b1;
                if (!i_start) begin
                    state_d = StIdle;
                    time_d  = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Sticky flags: clear first so a bit set on the same cycle survives.
    always_comb begin
        resp_d = i_clear ? '0 : resp_q;
        if (complete && (int'(step_q) < int'(N_STEPS))) begin
            resp_d[step_q] = 1'b1;
        end
    end

    // State, latches, counter, flags and done pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            step_q  <= '0;
            dur_q   <= '0;
            time_q  <= '0;
            resp_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            dur_q   <= dur_d;
            time_q  <= time_d;
            resp_q  <= resp_d;
            done_q  <= done_d;
        end
    end

    assign o_response = resp_q;
    assign o_done     = done_q;
    assign o_time     = time_q;
    assign o_remain   = dur_q - time_q;
    assign o_busy     = (state_q == StRun) || (state_q == StPause);

endmodule

// File: tb/tb_wash_phase_timer.sv
// Scoreboard bench for wash_phase_timer with a 1 kHz clock model (DIV 100 / 10).
module tb_wash_phase_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_start = 1'b0;
    logic        i_pause = 1'b0;
    logic        i_acc = 1'b0;
    logic [1:0]  i_step = '0;
    logic [15:0] i_duration = '0;
    logic        i_clear = 1'b0;
    logic [3:0]  o_response;
    logic        o_done;
    logic [15:0] o_time;
    logic [15:0] o_remain;
    logic        o_busy;

    typedef struct {
        logic [3:0]  resp;
        logic [15:0] tim;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   k;

    wash_phase_timer #(
        .CLK_HZ  (1000),
        .TICK_HZ (10),
        .ACC_HZ  (100),
        .TIME_W  (16),
        .N_STEPS (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (i_start),
        .i_pause    (i_pause),
        .i_acc      (i_acc),
        .i_step     (i_step),
        .i_duration (i_duration),
        .i_clear    (i_clear),
        .o_response (o_response),
        .o_done     (o_done),
        .o_time     (o_time),
        .o_remain   (o_remain),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && o_done === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_done: got done at cycle %0d want none", cyc);
            end else begin
                e = sb.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("done_resp", {28'd0, o_response}, {28'd0, e.resp});
                check("done_time", {16'd0, o_time}, {16'd0, e.tim});
                check("done_remain", {16'd0, o_remain}, 32'd0);
                check("done_busy", {31'd0, o_busy}, 32'd0);
            end
        end
    end

    task automatic step1();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int c);
        while (cyc < c) step1();
    endtask

    task automatic launch(input logic [1:0] s, input logic [15:0] d, input logic a,
                          output int kk);
        kk         = cyc;
        i_step     = s;
        i_duration = d;
        i_acc      = a;
        i_start    = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step1();
            n++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_time", {16'd0, o_time}, 32'd0);
        check("rst_remain", {16'd0, o_remain}, 32'd0);
        check("rst_resp", {28'd0, o_response}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        rst_n = 1'b1;
        step1();

        // Normal rate, 3 ticks of 100 clk.
        launch(2'd2, 16'd3, 1'b0, k);
        sb.push_back('{resp: 4'b0100, tim: 16'd3, cyc: k + 301});
        wait_drain(400);
        check("t1_hold_time", {16'd0, o_time}, 32'd3);
        check("t1_busy", {31'd0, o_busy}, 32'd0);
        i_start = 1'b0;
        step1();
        check("t1_idle_time", {16'd0, o_time}, 32'd0);

        // Accelerated rate, then relaunch the same step.
        launch(2'd1, 16'd5, 1'b1, k);
        sb.push_back('{resp: 4'b0110, tim: 16'd5, cyc: k + 51});
        wait_drain(100);
        i_start = 1'b0;
        step1();
        check("t2_idle_time", {16'd0, o_time}, 32'd0);
        check("t2_idle_busy", {31'd0, o_busy}, 32'd0);
        launch(2'd1, 16'd5, 1'b1, k);
        sb.push_back('{resp: 4'b0110, tim: 16'd5, cyc: k + 51});
        wait_drain(100);
        i_start = 1'b0;
        step1();

        // Pause for 250 clk after 150 clk of run; partial tick resumes.
        launch(2'd0, 16'd4, 1'b0, k);
        sb.push_back('{resp: 4'b0111, tim: 16'd4, cyc: k + 652});
        tick_to(k + 151);
        check("t3_prepause_time", {16'd0, o_time}, 32'd1);
        i_pause = 1'b1;
        tick_to(k + 200);
        check("t3_pause_time_a", {16'd0, o_time}, 32'd1);
        check("t3_pause_busy", {31'd0, o_busy}, 32'd1);
        tick_to(k + 400);
        check("t3_pause_time_b", {16'd0, o_time}, 32'd1);
        check("t3_pause_remain", {16'd0, o_remain}, 32'd3);
        tick_to(k + 401);
        i_pause = 1'b0;
        wait_drain(400);
        i_start = 1'b0;
        step1();

        // Abort at o_time 6: no done, flags unchanged.
        launch(2'd3, 16'd10, 1'b1, k);
        tick_to(k + 61);
        check("t4_before_abort", {16'd0, o_time}, 32'd6);
        i_start = 1'b0;
        step1();
        check("t4_abort_time", {16'd0, o_time}, 32'd0);
        check("t4_abort_busy", {31'd0, o_busy}, 32'd0);
        check("t4_abort_resp", {28'd0, o_response}, 32'd7);
        i_acc = 1'b0;
        step1();

        // Zero duration completes one cycle after run entry.
        launch(2'd3, 16'd0, 1'b0, k);
        sb.push_back('{resp: 4'b1111, tim: 16'd0, cyc: k + 2});
        wait_drain(10);
        i_start = 1'b0;
        step1();

        // Clear coincides with step-0 completion: only bit 0 survives.
        launch(2'd0, 16'd0, 1'b0, k);
        sb.push_back('{resp: 4'b0001, tim: 16'd0, cyc: k + 2});
        step1();
        i_clear = 1'b1;
        step1();
        i_clear = 1'b0;
        wait_drain(10);
        check("t5_resp_after_clear", {28'd0, o_response}, 32'd1);
        i_start = 1'b0;
        step1();

        // Async reset mid-run clears outputs without waiting for an edge.
        launch(2'd1, 16'd5, 1'b0, k);
        tick_to(k + 201);
        check("t6_prereset_time", {16'd0, o_time}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_time", {16'd0, o_time}, 32'd0);
        check("t6_rst_resp", {28'd0, o_response}, 32'd0);
        check("t6_rst_busy", {31'd0, o_busy}, 32'd0);
        check("t6_rst_remain", {16'd0, o_remain}, 32'd0);
        i_start = 1'b0;
        step1();
        rst_n = 1'b1;
        step1();

        // Rate switch with count 50 ticks on the next edge, then every 10 clk.
        launch(2'd2, 16'd5, 1'b0, k);
        sb.push_back('{resp: 4'b0100, tim: 16'd5, cyc: k + 92});
        tick_to(k + 51);
        check("t7_preswitch_time", {16'd0, o_time}, 32'd0);
        i_acc = 1'b1;
        step1();
        check("t7_switch_tick", {16'd0, o_time}, 32'd1);
        tick_to(k + 61);
        check("t7_no_double", {16'd0, o_time}, 32'd1);
        tick_to(k + 62);
        check("t7_next_tick", {16'd0, o_time}, 32'd2);
        wait_drain(100);
        check("t7_resp", {28'd0, o_response}, 32'd4);

        // Clear while holding in DONE.
        i_clear = 1'b1;
        step1();
        i_clear = 1'b0;
        check("t8_clear_resp", {28'd0, o_response}, 32'd0);
        i_start = 1'b0;
        i_acc = 1'b0;
        repeat (3) step1();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
